// File: rtl/rv_decode_stage.sv
// Registered RV32I/RV64I OP/OP-IMM decode stage with valid/ready handshake on both sides.
// Flags illegal encodings and keeps a saturating count of accepted illegal instructions.
module rv_decode_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_alu_op,
  output logic             out_reg_write,
  output logic             out_alu_src_imm,
  output logic [XLEN-1:0]  out_imm,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_count
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLL  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SLT  = 4'b0110;
  localparam logic [3:0] ALU_XOR  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  // RV64 shifts use a 6-bit shamt, so the SRAI marker loses its low bit
  localparam logic [6:0] SRA_UPPER = (XLEN == 64) ? 7'b0010000 : 7'b0100000;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  function automatic logic [3:0] aluFromF3(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'd0:    op = alt ? ALU_SUB : ALU_ADD;
      3'd1:    op = ALU_SLL;
      3'd2:    op = ALU_SLT;
      3'd3:    op = ALU_SLTU;
      3'd4:    op = ALU_XOR;
      3'd5:    op = alt ? ALU_SRA : ALU_SRL;
      3'd6:    op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [6:0]      shUpper;
  logic [5:0]      shamt;

  logic [3:0]      decAluOp;
  logic            decRegWrite;
  logic            decSrcImm;
  logic [XLEN-1:0] decImm;
  logic [4:0]      decRs2;
  logic            decIllegal;

  logic            valid_q, valid_d;
  logic [3:0]      aluOp_q;
  logic            regWrite_q;
  logic            srcImm_q;
  logic [XLEN-1:0] imm_q;
  logic [4:0]      rd_q, rs1_q, rs2_q;
  logic            illegal_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic            accept;

  assign opcode  = in_instr[6:0];
  assign funct3  = in_instr[14:12];
  assign funct7  = in_instr[31:25];
  assign shUpper = (XLEN == 64) ? {1'b0, in_instr[31:26]} : in_instr[31:25];
  assign shamt   = (XLEN == 64) ? in_instr[25:20] : {1'b0, in_instr[24:20]};

  always_comb begin
    decAluOp   = ALU_ADD;
    decSrcImm  = 1'b0;
    decImm     = '0;
    decRs2     = in_instr[24:20];
    decIllegal = 1'b1;
    if (opcode == OPC_OP) begin
      if (funct7 == 7'b0000000) begin
        decIllegal = 1'b0;
        decAluOp   = aluFromF3(funct3, 1'b0);
      end else if (funct7 == 7'b0100000 && (funct3 == 3'd0 || funct3 == 3'd5)) begin
        decIllegal = 1'b0;
        decAluOp   = aluFromF3(funct3, 1'b1);
      end
    end else if (opcode == OPC_OP_IMM) begin
      decRs2 = '0;
      if (funct3 == 3'd1) begin
        if (shUpper == 7'b0000000) begin
          decIllegal = 1'b0;
          decAluOp   = ALU_SLL;
          decSrcImm  = 1'b1;
          decImm     = {{(XLEN-6){1'b0}}, shamt};
        end
      end else if (funct3 == 3'd5) begin
        if (shUpper == 7'b0000000 || shUpper == SRA_UPPER) begin
          decIllegal = 1'b0;
          decAluOp   = (shUpper == SRA_UPPER) ? ALU_SRA : ALU_SRL;
          decSrcImm  = 1'b1;
          decImm     = {{(XLEN-6){1'b0}}, shamt};
        end
      end else begin
        decIllegal = 1'b0;
        decAluOp   = aluFromF3(funct3, 1'b0);
        decSrcImm  = 1'b1;
        decImm     = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
      end
    end
    decRegWrite = !decIllegal && (in_instr[11:7] != 5'd0);
  end

  assign in_ready = !flush && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // flush wins over both accept and consume
  always_comb begin
    valid_d = valid_q;
    if (flush)          valid_d = 1'b0;
    else if (accept)    valid_d = 1'b1;
    else if (out_ready) valid_d = 1'b0;
  end

  always_comb begin
    count_d = count_q;
    if (accept && decIllegal && count_q != CNT_MAX) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      aluOp_q    <= '0;
      regWrite_q <= 1'b0;
      srcImm_q   <= 1'b0;
      imm_q      <= '0;
      rd_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      illegal_q  <= 1'b0;
      count_q    <= '0;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      if (accept) begin
        aluOp_q    <= decAluOp;
        regWrite_q <= decRegWrite;
        srcImm_q   <= decSrcImm;
        imm_q      <= decImm;
        rd_q       <= in_instr[11:7];
        rs1_q      <= in_instr[19:15];
        rs2_q      <= decRs2;
        illegal_q  <= decIllegal;
      end
    end
  end

  assign out_valid       = valid_q;
  assign out_alu_op      = aluOp_q;
  assign out_reg_write   = regWrite_q;
  assign out_alu_src_imm = srcImm_q;
  assign out_imm         = imm_q;
  assign out_rd          = rd_q;
  assign out_rs1         = rs1_q;
  assign out_rs2         = rs2_q;
  assign out_illegal     = illegal_q;
  assign illegal_count   = count_q;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Directed testbench for rv_decode_stage (XLEN=32, CNT_W=2).
module tb_rv_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_alu_op;
  logic        out_reg_write;
  logic        out_alu_src_imm;
  logic [31:0] out_imm;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic        out_illegal;
  logic [1:0]  illegal_count;

  int checks = 0;
  int errors = 0;

  rv_decode_stage #(.XLEN(32), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_op(out_alu_op), .out_reg_write(out_reg_write),
    .out_alu_src_imm(out_alu_src_imm), .out_imm(out_imm),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_illegal(out_illegal), .illegal_count(illegal_count)
  );

  always #5 clk = ~clk;

  // Present one instruction for a single cycle, then sample just after the edge
  task automatic applyStimulus(input logic [31:0] instr);
    in_valid = 1'b1;
    in_instr = instr;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    #3;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b1;
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b expected 0", out_valid); end
    checks++; if (out_alu_op !== 4'd0) begin errors++; $display("[TB] FAIL reset_aluop got %h expected 0", out_alu_op); end
    checks++; if (out_imm !== 32'd0) begin errors++; $display("[TB] FAIL reset_imm got %h expected 0", out_imm); end
    checks++; if (illegal_count !== 2'd0) begin errors++; $display("[TB] FAIL reset_count got %0d expected 0", illegal_count); end
    @(negedge clk); rst_n = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_inready got %b expected 1", in_ready); end
  endtask

  task automatic test_op();
    out_ready = 1'b1;
    applyStimulus(32'h002081B3);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL add_valid got %b expected 1", out_valid); end
    checks++; if (out_alu_op !== 4'b0010) begin errors++; $display("[TB] FAIL add_aluop got %b expected 0010", out_alu_op); end
    checks++; if ({out_rd, out_rs1, out_rs2} !== {5'd3, 5'd1, 5'd2}) begin errors++; $display("[TB] FAIL add_regs got %0d/%0d/%0d expected 3/1/2", out_rd, out_rs1, out_rs2); end
    checks++; if ({out_reg_write, out_alu_src_imm, out_illegal} !== 3'b100) begin errors++; $display("[TB] FAIL add_flags got %b expected 100", {out_reg_write, out_alu_src_imm, out_illegal}); end
    applyStimulus(32'h407302B3);
    checks++; if (out_alu_op !== 4'b0100) begin errors++; $display("[TB] FAIL sub_aluop got %b expected 0100", out_alu_op); end
    checks++; if ({out_rd, out_rs1, out_rs2} !== {5'd5, 5'd6, 5'd7}) begin errors++; $display("[TB] FAIL sub_regs got %0d/%0d/%0d expected 5/6/7", out_rd, out_rs1, out_rs2); end
    applyStimulus(32'h0020C1B3);
    checks++; if (out_alu_op !== 4'b0111) begin errors++; $display("[TB] FAIL xor_aluop got %b expected 0111", out_alu_op); end
    applyStimulus(32'h402091B3);
    checks++; if ({out_illegal, out_reg_write, out_alu_op} !== {1'b1, 1'b0, 4'b0010}) begin errors++; $display("[TB] FAIL op_badf7 got ill=%b wr=%b op=%b expected 1 0 0010", out_illegal, out_reg_write, out_alu_op); end
  endtask

  task automatic test_op_imm();
    out_ready = 1'b1;
    applyStimulus(32'hFFF00093);
    checks++; if ({out_alu_op, out_alu_src_imm, out_reg_write} !== {4'b0010, 1'b1, 1'b1}) begin errors++; $display("[TB] FAIL addi_ctrl got op=%b imm=%b wr=%b expected 0010 1 1", out_alu_op, out_alu_src_imm, out_reg_write); end
    checks++; if (out_imm !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL addi_imm got %h expected ffffffff", out_imm); end
    checks++; if (out_rs2 !== 5'd0) begin errors++; $display("[TB] FAIL addi_rs2 got %0d expected 0", out_rs2); end
    applyStimulus(32'h7F00F213);
    checks++; if ({out_alu_op, out_imm, out_rd} !== {4'b0000, 32'h7F0, 5'd4}) begin errors++; $display("[TB] FAIL andi got op=%b imm=%h rd=%0d expected 0000 7f0 4", out_alu_op, out_imm, out_rd); end
    applyStimulus(32'h40315113);
    checks++; if ({out_alu_op, out_imm} !== {4'b1000, 32'd3}) begin errors++; $display("[TB] FAIL srai got op=%b imm=%h expected 1000 3", out_alu_op, out_imm); end
    applyStimulus(32'h01F09093);
    checks++; if ({out_alu_op, out_imm, out_illegal} !== {4'b0011, 32'd31, 1'b0}) begin errors++; $display("[TB] FAIL slli31 got op=%b imm=%h ill=%b expected 0011 1f 0", out_alu_op, out_imm, out_illegal); end
    applyStimulus(32'h02011093);
    checks++; if ({out_illegal, out_reg_write, out_alu_src_imm, out_imm} !== {3'b100, 32'd0}) begin errors++; $display("[TB] FAIL slli_bad got ill=%b wr=%b si=%b imm=%h expected 1 0 0 0", out_illegal, out_reg_write, out_alu_src_imm, out_imm); end
    applyStimulus(32'h00000000);
    checks++; if (out_illegal !== 1'b1) begin errors++; $display("[TB] FAIL bad_opcode got %b expected 1", out_illegal); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL drain_valid got %b expected 0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    applyStimulus(32'h002081B3);
    in_valid = 1'b1;
    in_instr = 32'h407302B3;
    for (int i = 0; i < 5; i++) begin
      checks++; if ({out_valid, in_ready, out_alu_op, out_rd} !== {1'b1, 1'b0, 4'b0010, 5'd3}) begin errors++; $display("[TB] FAIL hold_%0d got v=%b rdy=%b op=%b rd=%0d expected 1 0 0010 3", i, out_valid, in_ready, out_alu_op, out_rd); end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL release_ready got %b expected 1", in_ready); end
    @(posedge clk); #1;
    checks++; if ({out_valid, out_alu_op} !== {1'b1, 4'b0100}) begin errors++; $display("[TB] FAIL b2b_sub got v=%b op=%b expected 1 0100", out_valid, out_alu_op); end
    in_instr = 32'h0020C1B3;
    @(posedge clk); #1;
    checks++; if ({out_valid, out_alu_op} !== {1'b1, 4'b0111}) begin errors++; $display("[TB] FAIL b2b_xor got v=%b op=%b expected 1 0111", out_valid, out_alu_op); end
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_drain got %b expected 0", out_valid); end
  endtask

  task automatic test_counter();
    logic [1:0] expCount;
    doReset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_instr  = 32'h00000000;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      expCount = (i >= 2) ? 2'd3 : 2'(i + 1);
      checks++; if (illegal_count !== expCount) begin errors++; $display("[TB] FAIL count_%0d got %0d expected %0d", i, illegal_count, expCount); end
    end
    in_valid = 1'b0;
    applyStimulus(32'h00000033);
    checks++; if ({out_illegal, out_reg_write, out_alu_op, illegal_count} !== {1'b0, 1'b0, 4'b0010, 2'd3}) begin errors++; $display("[TB] FAIL add_x0 got ill=%b wr=%b op=%b cnt=%0d expected 0 0 0010 3", out_illegal, out_reg_write, out_alu_op, illegal_count); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    applyStimulus(32'h002081B3);
    in_valid = 1'b1;
    in_instr = 32'h00000000;
    flush    = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL flush_ready got %b expected 0", in_ready); end
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_valid got %b expected 0", out_valid); end
    checks++; if (illegal_count !== 2'd3) begin errors++; $display("[TB] FAIL flush_count got %0d expected 3", illegal_count); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    applyStimulus(32'h002081B3);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({out_valid, out_alu_op, out_rd, out_rs1, out_rs2, out_reg_write, illegal_count} !== '0) begin errors++; $display("[TB] FAIL async_reset got v=%b op=%b rd=%0d rs1=%0d rs2=%0d wr=%b cnt=%0d expected all 0", out_valid, out_alu_op, out_rd, out_rs1, out_rs2, out_reg_write, illegal_count); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_op();
    test_op_imm();
    test_backpressure();
    test_counter();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv_decode_stage.md
# rv_decode_stage

Registered RV32I/RV64I integer decode stage with a valid/ready handshake on both sides. It decodes R-type (OP) and I-type (OP-IMM) ALU instructions into the core's 4-bit ALU operation code, register indices, write-enable and a sign-extended immediate. It flags illegal encodings and keeps a saturating count of them. It sits between instruction fetch and the register-read/execute stage, and supersedes the purely combinational R-type-only control decoder.

## Interface

Parameters:
- XLEN, 32: datapath width, 32 or 64; sets the immediate width and the shift-amount rules.
- CNT_W, 8: width of the illegal-instruction counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous kill of the held output.
- in_valid  in  1  fetch presents in_instr.
- in_ready  out  1  stage accepts in_instr this cycle.
- in_instr  in  32  instruction word.
- out_valid  out  1  decoded fields valid.
- out_ready  in  1  downstream consumes the outputs this cycle.
- out_alu_op  out  4  ALU operation code.
- out_reg_write  out  1  write rd.
- out_alu_src_imm  out  1  operand B is out_imm, not rs2.
- out_imm  out  XLEN  immediate.
- out_rd, out_rs1, out_rs2  out  5 each  register indices.
- out_illegal  out  1  unsupported or malformed encoding.
- illegal_count  out  CNT_W  saturating count of accepted illegal instructions.

## Operation

ALU codes:
- AND 0000, OR 0001, ADD 0010, SLL 0011, SUB 0100, SRL 0101, SLT 0110, XOR 0111, SRA 1000, SLTU 1001.

OP (opcode 0110011):
- funct7 0000000: funct3 0 ADD, 1 SLL, 2 SLT, 3 SLTU, 4 XOR, 5 SRL, 6 OR, 7 AND.
- funct7 0100000: funct3 0 is SUB and funct3 5 is SRA.
- Any other funct7/funct3 pairing is illegal.
- out_alu_src_imm=0; out_imm=0.

OP-IMM (opcode 0010011):
- Same funct3 mapping, with out_alu_src_imm=1.
- For funct3 other than 1 and 5, out_imm = instr[31:20] sign-extended to XLEN.
- Shifts with XLEN=32: shamt = instr[24:20] and funct7 = instr[31:25].
- Shifts with XLEN=64: shamt = instr[25:20] and upper bits = instr[31:26].
- funct3 1 requires upper bits all zero. funct3 5 requires zero (SRLI) or 0100000/010000 (SRAI).
- For shifts, out_imm = shamt zero-extended. out_rs2 = 0 for OP-IMM.

Field and flag rules:
- out_rd = instr[11:7], out_rs1 = instr[19:15] and out_rs2 = instr[24:20] for OP.
- out_reg_write = 1 only for a legal instruction with rd != 0.
- Illegal (any other opcode or bad funct field): out_illegal=1, out_reg_write=0, out_alu_op=0010, out_alu_src_imm=0, out_imm=0.

Handshake and flush:
- Decode is combinational from in_instr into a single output register, loaded on accept (in_valid && in_ready).
- in_ready = !flush && (!out_valid || out_ready).
- out_valid: set on accept; cleared when out_valid && out_ready with no new accept, or on flush.
- flush has priority: out_valid goes to 0 next cycle and nothing is accepted that cycle.

illegal_count:
- Increments on accept of an illegal instruction and saturates at 2^CNT_W-1.
- Cleared only by reset; flush does not clear it.

## Timing

- Reset values: out_valid=0, every decoded output 0, illegal_count=0. in_ready=1 once rst_n is high and flush is low.
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 instruction per cycle while out_ready=1.
- in_ready depends combinationally on out_ready and flush. There is no skid buffer.
- Outputs must stay stable while out_valid && !out_ready.
- Accept and consume in the same cycle: the new instruction replaces the old one and out_valid stays 1.
- Reset asserted mid-operation drops the held instruction immediately. Outputs go to reset values asynchronously.

## Test plan

- 0x002081B3 (ADD x3,x1,x2), out_ready=1 -> next cycle: out_alu_op=0010, rd=3, rs1=1, rs2=2, reg_write=1, src_imm=0, illegal=0.
- 0x407302B3 (SUB x5,x6,x7) -> alu_op=0100. Then 0xFFF00093 (ADDI x1,x0,-1) -> alu_op=0010, src_imm=1, imm=0xFFFFFFFF (XLEN=32) or all ones (XLEN=64).
- 0x40315113 (SRAI x2,x2,3) -> alu_op=1000, imm=3. With XLEN=32, 0x02011093 (SLLI with instr[25]=1) -> illegal=1, reg_write=0.
- Backpressure: hold out_ready=0 with in_valid=1 -> one instruction held, in_ready=0, outputs stable for 5 cycles. Release -> held instruction consumed, next one follows one per cycle.
- Counter, with CNT_W=2: four 0x00000000 accepted -> illegal_count reads 1, 2, 3, 3. 0x00000033 (ADD x0,x0,x0) -> legal with reg_write=0.
- flush with out_valid=1 and in_valid=1 -> out_valid=0 next cycle, in_ready=0 during the flush cycle, counter unchanged. Assert rst_n=0 mid-stream -> all outputs 0 immediately.
